// File: rtl/dut_or_fifo.sv
// dut_or_fifo: two 2-entry operand FIFOs (A, B) feed an OR stage that
// pushes results into a 2-entry result FIFO (Y). The block is driven
// through a small address-mapped write/read port.
//
// Status and data reads are combinational from the current state.
// Every occupancy decision is made on the state at the start of the cycle,
// so an entry freed at an edge cannot be reused until the following cycle.
module dut_or_fifo (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] write_address,
  input  logic       write_data,
  input  logic       write_en,
  output logic       write_rdy,
  input  logic [2:0] read_address,
  input  logic       read_en,
  output logic       read_data,
  output logic       read_rdy
);

  localparam logic [2:0] ADDR_A_NOT_FULL  = 3'd0;
  localparam logic [2:0] ADDR_B_NOT_FULL  = 3'd1;
  localparam logic [2:0] ADDR_Y_NOT_EMPTY = 3'd2;
  localparam logic [2:0] ADDR_Y_HEAD      = 3'd3;
  localparam logic [2:0] ADDR_WRITE_A     = 3'd4;
  localparam logic [2:0] ADDR_WRITE_B     = 3'd5;

  // Operand FIFO A storage
  logic       a_mem [2];
  logic       a_rd_ptr;
  logic       a_wr_ptr;
  logic [1:0] a_count;

  // Operand FIFO B storage
  logic       b_mem [2];
  logic       b_rd_ptr;
  logic       b_wr_ptr;
  logic [1:0] b_count;

  // Result FIFO Y storage
  logic       y_mem [2];
  logic       y_rd_ptr;
  logic       y_wr_ptr;
  logic [1:0] y_count;

  // Start-of-cycle occupancy flags
  logic a_full, a_empty;
  logic b_full, b_empty;
  logic y_full, y_empty;

  // Per-cycle actions
  logic enq_a;
  logic enq_b;
  logic compute;
  logic deq_y;
  logic or_result;

  assign a_full  = (a_count == 2'd2);
  assign a_empty = (a_count == 2'd0);
  assign b_full  = (b_count == 2'd2);
  assign b_empty = (b_count == 2'd0);
  assign y_full  = (y_count == 2'd2);
  assign y_empty = (y_count == 2'd0);

  // Writes to a full FIFO are dropped silently; other addresses are ignored.
  assign enq_a = write_en && (write_address == ADDR_WRITE_A) && !a_full;
  assign enq_b = write_en && (write_address == ADDR_WRITE_B) && !b_full;

  // The OR stage fires only when both operands exist and Y has room at
  // cycle start; a Y dequeue in the same cycle does not unblock a full Y.
  assign compute   = !a_empty && !b_empty && !y_full;
  assign or_result = a_mem[a_rd_ptr] | b_mem[b_rd_ptr];

  assign deq_y = read_en && (read_address == ADDR_Y_HEAD) && !y_empty;

  assign write_rdy = !RST_N;
  assign read_rdy  = !RST_N;

  // FIFO A: enqueue from the write port, dequeue when the OR stage fires
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      a_rd_ptr <= 1'b0;
      a_wr_ptr <= 1'b0;
      a_count  <= 2'd0;
    end else begin
      if (enq_a) begin
        a_mem[a_wr_ptr] <= write_data;
        a_wr_ptr        <= ~a_wr_ptr;
      end
      if (compute) begin
        a_rd_ptr <= ~a_rd_ptr;
      end
      case ({enq_a, compute})
        2'b10:   a_count <= a_count + 2'd1;
        2'b01:   a_count <= a_count - 2'd1;
        default: a_count <= a_count;
      endcase
    end
  end

  // FIFO B: enqueue from the write port, dequeue when the OR stage fires
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      b_rd_ptr <= 1'b0;
      b_wr_ptr <= 1'b0;
      b_count  <= 2'd0;
    end else begin
      if (enq_b) begin
        b_mem[b_wr_ptr] <= write_data;
        b_wr_ptr        <= ~b_wr_ptr;
      end
      if (compute) begin
        b_rd_ptr <= ~b_rd_ptr;
      end
      case ({enq_b, compute})
        2'b10:   b_count <= b_count + 2'd1;
        2'b01:   b_count <= b_count - 2'd1;
        default: b_count <= b_count;
      endcase
    end
  end

  // FIFO Y: enqueue OR results, dequeue on a read of the head address
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      y_rd_ptr <= 1'b0;
      y_wr_ptr <= 1'b0;
      y_count  <= 2'd0;
    end else begin
      if (compute) begin
        y_mem[y_wr_ptr] <= or_result;
        y_wr_ptr        <= ~y_wr_ptr;
      end
      if (deq_y) begin
        y_rd_ptr <= ~y_rd_ptr;
      end
      case ({compute, deq_y})
        2'b10:   y_count <= y_count + 2'd1;
        2'b01:   y_count <= y_count - 2'd1;
        default: y_count <= y_count;
      endcase
    end
  end

  // Read mux: status flags and Y head, zero for unmapped addresses
  always_comb begin
    read_data = 1'b0;
    case (read_address)
      ADDR_A_NOT_FULL:  read_data = !a_full;
      ADDR_B_NOT_FULL:  read_data = !b_full;
      ADDR_Y_NOT_EMPTY: read_data = !y_empty;
      ADDR_Y_HEAD:      read_data = y_empty ? 1'b0 : y_mem[y_rd_ptr];
      default:          read_data = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dut_or_fifo.sv
// tb_dut_or_fifo: scenario-driven bench for dut_or_fifo. Operand pairs push
// their expected OR result onto a scoreboard queue; Y head reads pop it.
module tb_dut_or_fifo;

  logic       CLK;
  logic       RST_N;
  logic [2:0] write_address;
  logic       write_data;
  logic       write_en;
  logic       write_rdy;
  logic [2:0] read_address;
  logic       read_en;
  logic       read_data;
  logic       read_rdy;

  int check_count = 0;
  int pass_count  = 0;
  logic sb [$];

  dut_or_fifo dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .write_address (write_address),
    .write_data    (write_data),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .read_address  (read_address),
    .read_en       (read_en),
    .read_data     (read_data),
    .read_rdy      (read_rdy)
  );

  // 10-unit clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One bus cycle: drive at negedge, sample read_data, let the edge commit.
  task automatic drive_cycle(input logic we, input logic [2:0] wa, input logic wd,
                             input logic re, input logic [2:0] ra, output logic rd);
    @(negedge CLK);
    write_en      = we;
    write_address = wa;
    write_data    = wd;
    read_en       = re;
    read_address  = ra;
    #1 rd = read_data;
    @(posedge CLK);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] wa, input logic wd);
    logic unused;
    drive_cycle(1'b1, wa, wd, 1'b0, 3'd0, unused);
  endtask

  task automatic peek(input logic [2:0] ra, output logic rd);
    drive_cycle(1'b0, 3'd0, 1'b0, 1'b0, ra, rd);
  endtask

  task automatic pop_y(output logic rd);
    drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 3'd3, rd);
  endtask

  // Poll "Y not empty" for a bounded number of cycles.
  task automatic wait_y(output logic found);
    logic rd;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      peek(3'd2, rd);
      if (rd === 1'b1) found = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N    = 1'b1;
    write_en = 1'b0;
    read_en  = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_count++;
    if ({write_rdy, read_rdy} !== 2'b00) $display("[TB] FAIL rdy_in_reset: got %b, expected 00", {write_rdy, read_rdy});
    else pass_count++;
    @(posedge CLK);
    #1 RST_N = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    logic rd;
    logic [3:0] expected = 4'b0011;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      peek(3'(a), rd);
      check_count++;
      if (rd !== expected[a]) $display("[TB] FAIL reset_read_addr%0d: got %b, expected %b", a, rd, expected[a]);
      else pass_count++;
    end
    check_count++;
    if ({write_rdy, read_rdy} !== 2'b11) $display("[TB] FAIL rdy_after_reset: got %b, expected 11", {write_rdy, read_rdy});
    else pass_count++;
  endtask

  task automatic test_or_pairs();
    logic rd, found, a, b, exp;
    for (int p = 0; p < 4; p++) begin
      a = p[1];
      b = p[0];
      do_write(3'd4, a);
      do_write(3'd5, b);
      sb.push_back(a | b);
      wait_y(found);
      check_count++;
      if (found !== 1'b1) $display("[TB] FAIL or_pair%0d_wait: got timeout, expected Y not empty", p);
      else pass_count++;
      pop_y(rd);
      exp = sb.pop_front();
      check_count++;
      if (rd !== exp) $display("[TB] FAIL or_pair%0d_result: got %b, expected %b", p, rd, exp);
      else pass_count++;
      peek(3'd2, rd);
      check_count++;
      if (rd !== 1'b0) $display("[TB] FAIL or_pair%0d_y_empty: got %b, expected 0", p, rd);
      else pass_count++;
    end
  endtask

  task automatic test_a_full_drop();
    logic rd, found, exp;
    do_reset();
    do_write(3'd4, 1'b1);
    do_write(3'd4, 1'b0);
    peek(3'd0, rd);
    check_count++;
    if (rd !== 1'b0) $display("[TB] FAIL a_full_flag: got %b, expected 0", rd);
    else pass_count++;
    do_write(3'd4, 1'b1);
    do_write(3'd5, 1'b0);
    sb.push_back(1'b1);
    do_write(3'd5, 1'b0);
    sb.push_back(1'b0);
    for (int i = 0; i < 2; i++) begin
      wait_y(found);
      pop_y(rd);
      exp = sb.pop_front();
      check_count++;
      if (rd !== exp) $display("[TB] FAIL a_drop_result%0d: got %b, expected %b", i, rd, exp);
      else pass_count++;
    end
    repeat (3) peek(3'd2, rd);
    check_count++;
    if (rd !== 1'b0) $display("[TB] FAIL a_drop_no_extra: got %b, expected 0", rd);
    else pass_count++;
    peek(3'd0, rd);
    check_count++;
    if (rd !== 1'b1) $display("[TB] FAIL a_drop_a_empty: got %b, expected 1", rd);
    else pass_count++;
  endtask

  task automatic test_y_backpressure();
    logic rd, exp;
    do_reset();
    do_write(3'd4, 1'b1);
    do_write(3'd5, 1'b0);
    sb.push_back(1'b1);
    do_write(3'd4, 1'b0);
    do_write(3'd5, 1'b0);
    sb.push_back(1'b0);
    do_write(3'd4, 1'b0);
    do_write(3'd5, 1'b1);
    sb.push_back(1'b1);
    repeat (3) peek(3'd2, rd);
    check_count++;
    if (rd !== 1'b1) $display("[TB] FAIL bp_y_not_empty: got %b, expected 1", rd);
    else pass_count++;
    peek(3'd3, rd);
    check_count++;
    if (rd !== sb[0]) $display("[TB] FAIL bp_head_peek: got %b, expected %b", rd, sb[0]);
    else pass_count++;
    do_write(3'd4, 1'b1);
    peek(3'd0, rd);
    check_count++;
    if (rd !== 1'b0) $display("[TB] FAIL bp_a_retained: got %b, expected 0", rd);
    else pass_count++;
    for (int i = 0; i < 3; i++) begin
      pop_y(rd);
      exp = sb.pop_front();
      check_count++;
      if (rd !== exp) $display("[TB] FAIL bp_result%0d: got %b, expected %b", i, rd, exp);
      else pass_count++;
    end
    peek(3'd2, rd);
    check_count++;
    if (rd !== 1'b0) $display("[TB] FAIL bp_y_drained: got %b, expected 0", rd);
    else pass_count++;
  endtask

  task automatic test_mid_reset();
    logic rd, found, exp;
    logic [3:0] expected = 4'b0011;
    do_reset();
    do_write(3'd4, 1'b1);
    do_write(3'd5, 1'b1);
    do_write(3'd4, 1'b0);
    do_write(3'd5, 1'b0);
    do_write(3'd4, 1'b1);
    do_write(3'd5, 1'b1);
    @(negedge CLK);
    RST_N         = 1'b1;
    write_en      = 1'b1;
    write_address = 3'd4;
    write_data    = 1'b1;
    @(posedge CLK);
    #1;
    RST_N    = 1'b0;
    write_en = 1'b0;
    sb.delete();
    for (int a = 0; a < 4; a++) begin
      peek(3'(a), rd);
      check_count++;
      if (rd !== expected[a]) $display("[TB] FAIL mid_reset_addr%0d: got %b, expected %b", a, rd, expected[a]);
      else pass_count++;
    end
    do_write(3'd4, 1'b0);
    do_write(3'd5, 1'b1);
    sb.push_back(1'b1);
    wait_y(found);
    pop_y(rd);
    exp = sb.pop_front();
    check_count++;
    if (rd !== exp) $display("[TB] FAIL post_reset_result: got %b, expected %b", rd, exp);
    else pass_count++;
  endtask

  task automatic test_bad_addresses();
    logic rd;
    logic [2:0] bad_writes [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    do_reset();
    foreach (bad_writes[i]) do_write(bad_writes[i], 1'b1);
    for (int a = 4; a < 8; a++) begin
      drive_cycle(1'b0, 3'd0, 1'b0, 1'b1, 3'(a), rd);
      check_count++;
      if (rd !== 1'b0) $display("[TB] FAIL bad_read_addr%0d: got %b, expected 0", a, rd);
      else pass_count++;
    end
    for (int a = 0; a < 3; a++) begin
      peek(3'(a), rd);
      check_count++;
      if (rd !== (a < 2)) $display("[TB] FAIL bad_addr_state%0d: got %b, expected %b", a, rd, (a < 2));
      else pass_count++;
    end
  endtask

  // Scenario sequence
  initial begin
    RST_N         = 1'b1;
    write_en      = 1'b0;
    write_address = 3'd0;
    write_data    = 1'b0;
    read_en       = 1'b0;
    read_address  = 3'd0;
    test_reset();
    test_or_pairs();
    test_a_full_drop();
    test_y_backpressure();
    test_mid_reset();
    test_bad_addresses();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/dut_or_fifo.md
DUT_OR_FIFO -- requirements
Module: dut

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST_N, input, 1 bit: reset, synchronous and active-high (1 = reset asserted; sampled on the CLK rising edge).
REQ-003 SHALL have port write_address, input, 3 bits: target of a write.
REQ-004 SHALL have port write_data, input, 1 bit: write payload.
REQ-005 SHALL have port write_en, input, 1 bit: write strobe, one write per cycle while high.
REQ-006 SHALL have port write_rdy, output, 1 bit: write method ready; constant 1 outside reset.
REQ-007 SHALL have port read_address, input, 3 bits: source of a read.
REQ-008 SHALL have port read_en, input, 1 bit: read strobe; side effects apply at the rising edge ending the cycle.
REQ-009 SHALL have port read_data, output, 1 bit: read result, combinational from read_address and current state, valid in the same cycle.
REQ-010 SHALL have port read_rdy, output, 1 bit: read method ready; constant 1 outside reset.

Function
REQ-011 SHALL contain three 2-entry FIFOs of 1-bit entries: A, B (inputs) and Y (output).
REQ-012 Write, write_en=1, address 4: SHALL enqueue write_data into A if A is not full at cycle start, else drop it silently.
REQ-013 Write, write_en=1, address 5: SHALL enqueue write_data into B with the same full rule.
REQ-014 Writes to any other address SHALL be ignored.
REQ-015 read_data per read_address: 0 = A not full; 1 = B not full; 2 = Y not empty; 3 = head of Y, or 0 if Y is empty; other addresses = 0.
REQ-016 Read with read_en=1, address 3, Y not empty: SHALL dequeue Y at the edge.
REQ-017 All other reads SHALL have no side effect.
REQ-018 Compute rule: on each edge where A and B are non-empty and Y is not full (all judged at cycle start), SHALL dequeue A and B and enqueue (A.head OR B.head) into Y.
REQ-019 Latency: an operand pair completed at edge k SHALL be computed at edge k+1, with Y readable in the cycle after edge k+1.
REQ-020 Full/empty flags SHALL be judged on start-of-cycle state. A write to a full FIFO is dropped even if compute frees an entry in the same cycle.
REQ-021 The following SHALL all commit at the same edge when each is individually legal: enqueue A, enqueue B, compute, and dequeue Y.
REQ-022 When Y holds 2 entries, a compute in the same cycle as a Y dequeue SHALL stall (Y full at cycle start).
REQ-023 FIFO order SHALL be strictly first-in first-out, and pointers SHALL wrap modulo 2.
REQ-024 write_rdy and read_rdy SHALL be 0 while RST_N=1 and 1 otherwise.
REQ-025 Inputs during reset SHALL be ignored.

Reset
REQ-026 While RST_N=1 at a rising edge, all FIFOs SHALL become empty and all pending data SHALL be discarded, including reset asserted mid-operation.
REQ-027 After reset: read addresses 0 and 1 SHALL return 1, addresses 2 and 3 SHALL return 0.
REQ-028 Release: the first cycle with RST_N=0 SHALL accept reads and writes.

Verification
REQ-029 Reset, then read addresses 0, 1, 2, 3 -> 1, 1, 0, 0.
REQ-030 For each (a,b) in {00,01,10,11}: write 4=a, 5=b; wait for read address 2 = 1; read address 3 -> a|b, then read address 2 = 0.
REQ-031 Write address 4 three times (1,0,1) with no B writes -> after the second write read address 0 = 0; the third write is dropped; later B writes 0,0 yield Y results 1 then 0.
REQ-032 Fill Y with 2 results plus 1 more operand pair -> A/B not consumed (read address 0 ≠ full-drop); one read of address 3 lets compute resume; three reads of address 3 -> results in order.
REQ-033 Assert RST_N=1 with data in A, B and Y -> next cycle read addresses 0..3 -> 1, 1, 0, 0.
REQ-034 Writes to addresses 0-3, 6 and 7, and reads of addresses 4-7 -> no state change, read_data = 0.
